// File: rtl/rdma_pkg.sv
// Constants and types shared by the RDMA initiator-side remap and responder-side unmap.
// Changing the window or base here moves both sides together.
package rdma_pkg;

  localparam int          RDMA_ADDR_W      = 32;
  localparam logic [31:0] RDMA_REMOTE_BASE = 32'h8000_0000;
  localparam logic [31:0] RDMA_WINDOW      = 32'h8000_0000;
  localparam int          RDMA_PAGE_BYTES  = 4096;
  localparam int          RDMA_PAGE_W      = $clog2(RDMA_PAGE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SPLIT = 2'd2
  } unmap_state_e;

endpackage

// File: rtl/rdma_unmap_check.sv
// Combinational translate/validate stage: remote address to local offset, window check,
// and 4 KiB page-split lengths for one request.
module rdma_unmap_check
  import rdma_pkg::*;
#(
  parameter int                ADDR_W      = RDMA_ADDR_W,
  parameter int                LEN_W       = 16,
  parameter logic [ADDR_W-1:0] REMOTE_BASE = RDMA_REMOTE_BASE,
  parameter logic [ADDR_W-1:0] WINDOW      = RDMA_WINDOW
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] off,
  output logic              err,
  output logic              split,
  output logic [LEN_W-1:0]  len0,
  output logic [LEN_W-1:0]  len1
);

  localparam logic [ADDR_W:0] WIN_EXT = {1'b0, WINDOW};

  logic [ADDR_W:0]          off_ext;
  logic [ADDR_W:0]          end_ext;
  logic [RDMA_PAGE_W-1:0]   page_off;
  logic [LEN_W:0]           span;

  // Range checks are done one bit wider so off + len cannot wrap past the window.
  assign off      = addr - REMOTE_BASE;
  assign off_ext  = {1'b0, off};
  assign end_ext  = off_ext + (ADDR_W+1)'(len);
  assign err      = (len == '0) || (len > LEN_W'(RDMA_PAGE_BYTES)) ||
                    (off_ext >= WIN_EXT) || (end_ext > WIN_EXT);

  assign page_off = off[RDMA_PAGE_W-1:0];
  assign span     = (LEN_W+1)'(page_off) + (LEN_W+1)'(len);
  assign split    = !err && (span > (LEN_W+1)'(RDMA_PAGE_BYTES));
  assign len0     = LEN_W'(RDMA_PAGE_BYTES) - LEN_W'(page_off);
  assign len1     = len - len0;

endmodule

// File: rtl/rdma_unmap.sv
// Responder-side RDMA address unmap: one registered response slot, page-split sequencing
// through a pending second-beat register, and a saturating rejected-request counter.
module rdma_unmap
  import rdma_pkg::*;
#(
  parameter int                ADDR_W      = RDMA_ADDR_W,
  parameter int                LEN_W       = 16,
  parameter int                TAG_W       = 4,
  parameter logic [ADDR_W-1:0] REMOTE_BASE = RDMA_REMOTE_BASE,
  parameter logic [ADDR_W-1:0] WINDOW      = RDMA_WINDOW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [LEN_W-1:0]  resp_len,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              resp_last,
  output logic [15:0]       err_count
);

  unmap_state_e      state, state_nxt;
  logic [ADDR_W-1:0] chk_off;
  logic              chk_err, chk_split;
  logic [LEN_W-1:0]  chk_len0, chk_len1;
  logic [ADDR_W-1:0] pend_addr;
  logic [LEN_W-1:0]  pend_len;
  logic              accept, consume, load_pend;

  rdma_unmap_check #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .REMOTE_BASE (REMOTE_BASE),
    .WINDOW      (WINDOW)
  ) u_check (
    .addr  (req_addr),
    .len   (req_len),
    .off   (chk_off),
    .err   (chk_err),
    .split (chk_split),
    .len0  (chk_len0),
    .len1  (chk_len1)
  );

  assign resp_valid = (state != ST_IDLE);
  // A presented beat 0 must hand over to beat 1, so SPLIT never frees the slot for a new request.
  assign req_ready  = rst_n && (!resp_valid || (resp_ready && state != ST_SPLIT));
  assign accept     = req_valid && req_ready;
  assign consume    = resp_valid && resp_ready;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load_pend = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept)       state_nxt = chk_split ? ST_SPLIT : ST_HOLD;
        else if (consume) state_nxt = ST_IDLE;
      end
      ST_SPLIT: begin
        if (consume) begin
          state_nxt = ST_HOLD;
          load_pend = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_addr <= '0;
      resp_len  <= '0;
      resp_tag  <= '0;
      resp_err  <= 1'b0;
      resp_last <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        resp_addr <= chk_err ? '0 : chk_off;
        resp_len  <= chk_split ? chk_len0 : req_len;
        resp_tag  <= req_tag;
        resp_err  <= chk_err;
        resp_last <= !chk_split;
        if (chk_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (load_pend) begin
        resp_addr <= pend_addr;
        resp_len  <= pend_len;
        resp_err  <= 1'b0;
        resp_last <= 1'b1;
      end
    end
  end

  // NOTE: the pending beat is only ever read in SPLIT, which reset leaves, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && chk_split) begin
      pend_addr <= chk_off + ADDR_W'(chk_len0);
      pend_len  <= chk_len1;
    end
  end

endmodule

// File: tb/tb_rdma_unmap.sv
// Bench for rdma_unmap: table of translate/check vectors on a standalone rdma_unmap_check,
// then directed handshake sequences on the top level.
module tb_rdma_unmap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_addr;
  logic [15:0] resp_len;
  logic [3:0]  resp_tag;
  logic        resp_err;
  logic        resp_last;
  logic [15:0] err_count;

  logic [31:0] ck_addr;
  logic [15:0] ck_len;
  logic [31:0] ck_off;
  logic        ck_err, ck_split;
  logic [15:0] ck_len0, ck_len1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rdma_unmap dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_len   (resp_len),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err),
    .resp_last  (resp_last),
    .err_count  (err_count)
  );

  rdma_unmap_check u_ck (
    .addr  (ck_addr),
    .len   (ck_len),
    .off   (ck_off),
    .err   (ck_err),
    .split (ck_split),
    .len0  (ck_len0),
    .len1  (ck_len1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic [31:0] off;
    logic        err;
    logic        split;
    logic [15:0] len0;
    logic [15:0] len1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request just after a rising edge and holds it until accepted.
  task automatic do_req(input logic [31:0] a, input logic [15:0] l, input logic [3:0] t);
    bit accepted = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = l; req_tag = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        accepted = 1;
        break;
      end
    end
    req_valid = 1'b0;
    check("req_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic expect_beat(input string name, input logic [31:0] a, input logic [15:0] l,
                             input logic [3:0] t, input logic e, input logic last);
    bit seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
    check({name, "_valid"}, 32'(seen), 32'd1);
    check({name, "_addr"}, resp_addr, a);
    check({name, "_len"}, 32'(resp_len), 32'(l));
    check({name, "_tag"}, 32'(resp_tag), 32'(t));
    check({name, "_err"}, 32'(resp_err), 32'(e));
    check({name, "_last"}, 32'(resp_last), 32'(last));
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_tag = '0;
    resp_ready = 1'b0; ck_addr = '0; ck_len = '0;

    // addr, len, off, err, split, len0, len1 (lens compared only on splits)
    vecs[0]  = '{32'h8000_1000, 16'h0100, 32'h0000_1000, 1'b0, 1'b0, 16'h0, 16'h0};
    vecs[1]  = '{32'h7FFF_0000, 16'h0010, 32'hFFFF_0000, 1'b1, 1'b0, 16'h0, 16'h0};
    vecs[2]  = '{32'h8000_0F80, 16'h0100, 32'h0000_0F80, 1'b0, 1'b1, 16'h0080, 16'h0080};
    vecs[3]  = '{32'hFFFF_FF00, 16'h0100, 32'h7FFF_FF00, 1'b0, 1'b0, 16'h0, 16'h0};
    vecs[4]  = '{32'hFFFF_FF00, 16'h0101, 32'h7FFF_FF00, 1'b1, 1'b0, 16'h0, 16'h0};
    vecs[5]  = '{32'h8000_0000, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 16'h0, 16'h0};
    vecs[6]  = '{32'h8000_0000, 16'h1000, 32'h0000_0000, 1'b0, 1'b0, 16'h0, 16'h0};
    vecs[7]  = '{32'h8000_0000, 16'h1001, 32'h0000_0000, 1'b1, 1'b0, 16'h0, 16'h0};
    vecs[8]  = '{32'h8000_0001, 16'h1000, 32'h0000_0001, 1'b0, 1'b1, 16'h0FFF, 16'h0001};
    vecs[9]  = '{32'h0000_0000, 16'h0010, 32'h8000_0000, 1'b1, 1'b0, 16'h0, 16'h0};
    vecs[10] = '{32'hFFFF_FFFF, 16'h0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 16'h0, 16'h0};
    vecs[11] = '{32'h8000_2FF0, 16'h0020, 32'h0000_2FF0, 1'b0, 1'b1, 16'h0010, 16'h0010};

    for (int i = 0; i < 12; i++) begin
      ck_addr = vecs[i].addr;
      ck_len  = vecs[i].len;
      #1;
      check($sformatf("ck%0d_off", i), ck_off, vecs[i].off);
      check($sformatf("ck%0d_err", i), 32'(ck_err), 32'(vecs[i].err));
      check($sformatf("ck%0d_split", i), 32'(ck_split), 32'(vecs[i].split));
      if (vecs[i].split) begin
        check($sformatf("ck%0d_len0", i), 32'(ck_len0), 32'(vecs[i].len0));
        check($sformatf("ck%0d_len1", i), 32'(ck_len1), 32'(vecs[i].len1));
      end
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_addr", resp_addr, 32'd0);
    check("rst_len", 32'(resp_len), 32'd0);
    check("rst_tag", 32'(resp_tag), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_last", 32'(resp_last), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic translation
    do_req(32'h8000_1000, 16'h0100, 4'd3);
    expect_beat("basic", 32'h0000_1000, 16'h0100, 4'd3, 1'b0, 1'b1);
    consume();
    @(negedge clk);
    check("basic_drained", 32'(resp_valid), 32'd0);

    // Below base
    do_req(32'h7FFF_0000, 16'h0010, 4'd5);
    expect_beat("below", 32'h0, 16'h0010, 4'd5, 1'b1, 1'b1);
    check("below_errcnt", 32'(err_count), 32'd1);
    consume();

    // Page split: beat 1 follows consumption of beat 0, and req_ready stays low meanwhile
    do_req(32'h8000_0F80, 16'h0100, 4'd7);
    expect_beat("split0", 32'h0000_0F80, 16'h0080, 4'd7, 1'b0, 1'b0);
    check("split0_ready_idle", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    #1;
    check("split0_ready_consume", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    expect_beat("split1", 32'h0000_1000, 16'h0080, 4'd7, 1'b0, 1'b1);
    check("split1_ready", 32'(req_ready), 32'd0);
    consume();
    @(negedge clk);
    check("split_drained", 32'(resp_valid), 32'd0);

    // Window edge
    do_req(32'hFFFF_FF00, 16'h0100, 4'd1);
    expect_beat("edge_ok", 32'h7FFF_FF00, 16'h0100, 4'd1, 1'b0, 1'b1);
    consume();
    do_req(32'hFFFF_FF00, 16'h0101, 4'd2);
    expect_beat("edge_over", 32'h0, 16'h0101, 4'd2, 1'b1, 1'b1);
    consume();
    @(negedge clk);
    check("edge_over_nosplit", 32'(resp_valid), 32'd0);
    check("edge_errcnt", 32'(err_count), 32'd2);
    do_req(32'h8000_0000, 16'h0000, 4'd3);
    expect_beat("len0", 32'h0, 16'h0000, 4'd3, 1'b1, 1'b1);
    check("len0_errcnt", 32'(err_count), 32'd3);
    consume();

    // Backpressure: held beat is stable and the request side is blocked
    do_req(32'h8000_2000, 16'h0040, 4'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_addr", c), resp_addr, 32'h0000_2000);
      check($sformatf("bp%0d_len", c), 32'(resp_len), 32'h40);
      check($sformatf("bp%0d_tag", c), 32'(resp_tag), 32'd9);
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
    end
    consume();

    // Streaming: 8 back-to-back requests, one beat per cycle in tag order
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000 + 32'(i) * 32'h100;
        req_len   = 16'h0010;
        req_tag   = 4'(i);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("st%0d_valid", i - 1), 32'(resp_valid), 32'd1);
        check($sformatf("st%0d_tag", i - 1), 32'(resp_tag), 32'(i - 1));
        check($sformatf("st%0d_addr", i - 1), resp_addr, 32'(i - 1) * 32'h100);
      end
      if (i < 8) check($sformatf("st%0d_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    @(negedge clk);
    check("st_drained", 32'(resp_valid), 32'd0);

    // Reset while in SPLIT: beat 1 is discarded
    do_req(32'h8000_0F80, 16'h0100, 4'hC);
    expect_beat("rsplit0", 32'h0000_0F80, 16'h0080, 4'hC, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rsplit_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rsplit_valid", 32'(resp_valid), 32'd0);
    check("rsplit_errcnt", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rsplit_nobeat%0d", c), 32'(resp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
